hog_window_scanner: RTL and testbench

Parametrised detection-window assembler for the HOG pipeline. It sits between block normalisation and the classifier. It accepts normalised block descriptors in raster order and emits complete WIN_BLOCKS_X × WIN_BLOCKS_Y windows with a valid/ready handshake on both sides. It adds what the previous window stage lacked: configurable window and image geometry, independent X/Y window stride, border suppression, window coordinates, a last-window flag, start-of-frame resync, and back-pressure propagated to the input.

---
 rtl/hog_window_scanner.sv | 164 ++++++++++++++++
 tb/tb_hog_window_scanner.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hog_window_scanner.sv
// Detection-window assembler: turns a raster stream of normalised HOG blocks into
// WIN_BLOCKS_X x WIN_BLOCKS_Y windows with stride, border suppression and frame resync.
module hog_window_scanner #(
  parameter int IMAGE_BLOCKS_X = 40,
  parameter int IMAGE_BLOCKS_Y = 30,
  parameter int WIN_BLOCKS_X   = 4,
  parameter int WIN_BLOCKS_Y   = 8,
  parameter int BLOCK_WIDTH    = 36,
  parameter int STEP_X         = 1,
  parameter int STEP_Y         = 1,
  localparam int XW    = (IMAGE_BLOCKS_X > 1) ? $clog2(IMAGE_BLOCKS_X) : 1,
  localparam int YW    = (IMAGE_BLOCKS_Y > 1) ? $clog2(IMAGE_BLOCKS_Y) : 1,
  localparam int WIN_W = WIN_BLOCKS_X * WIN_BLOCKS_Y * BLOCK_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  input  logic [BLOCK_WIDTH-1:0] in_block,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIN_W-1:0]       out_window,
  output logic [XW-1:0]          out_win_x,
  output logic [YW-1:0]          out_win_y,
  output logic                   out_last
);

  localparam int LB_ROWS = WIN_BLOCKS_Y - 1;
  localparam int PXW = (STEP_X > 1) ? $clog2(STEP_X) : 1;
  localparam int PYW = (STEP_Y > 1) ? $clog2(STEP_Y) : 1;

  localparam logic [XW-1:0]  COL_LAST = XW'(IMAGE_BLOCKS_X - 1);
  localparam logic [YW-1:0]  ROW_LAST = YW'(IMAGE_BLOCKS_Y - 1);
  localparam logic [XW-1:0]  COL_MIN  = XW'(WIN_BLOCKS_X - 1);
  localparam logic [YW-1:0]  ROW_MIN  = YW'(WIN_BLOCKS_Y - 1);
  localparam logic [PXW-1:0] PX_LAST  = PXW'(STEP_X - 1);
  localparam logic [PYW-1:0] PY_LAST  = PYW'(STEP_Y - 1);
  // Phase counters hold col mod STEP_X / row mod STEP_Y, so the stride test is a
  // compare against the phase of the first legal window edge.
  localparam logic [PXW-1:0] PX_ELIG  = PXW'((WIN_BLOCKS_X - 1) % STEP_X);
  localparam logic [PYW-1:0] PY_ELIG  = PYW'((WIN_BLOCKS_Y - 1) % STEP_Y);

  logic [XW-1:0]  r_col;
  logic [YW-1:0]  r_row;
  logic [PXW-1:0] r_px;
  logic [PYW-1:0] r_py;

  logic                   r_out_valid;
  logic [WIN_W-1:0]       r_out_window;
  logic [XW-1:0]          r_out_win_x;
  logic [YW-1:0]          r_out_win_y;
  logic                   r_out_last;

  logic [BLOCK_WIDTH-1:0] r_lb  [LB_ROWS][IMAGE_BLOCKS_X];
  logic [BLOCK_WIDTH-1:0] r_win [WIN_BLOCKS_X][WIN_BLOCKS_Y];

  logic                   w_accept;
  logic                   w_elig;
  logic [XW-1:0]          w_col;
  logic [YW-1:0]          w_row;
  logic [PXW-1:0]         w_px;
  logic [PYW-1:0]         w_py;
  logic [BLOCK_WIDTH-1:0] w_col_blk [WIN_BLOCKS_Y];
  logic [WIN_W-1:0]       w_win_next;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // An accepted start-of-frame block is position (0,0) whatever the counters say.
  assign w_col = in_sof ? '0 : r_col;
  assign w_row = in_sof ? '0 : r_row;
  assign w_px  = in_sof ? '0 : r_px;
  assign w_py  = in_sof ? '0 : r_py;

  assign w_elig = (w_col >= COL_MIN) && (w_row >= ROW_MIN) &&
                  (w_px == PX_ELIG) && (w_py == PY_ELIG);

  always_comb begin
    for (int r = 0; r < LB_ROWS; r++) begin
      w_col_blk[r] = r_lb[r][w_col];
    end
    w_col_blk[LB_ROWS] = in_block;
  end

  always_comb begin
    w_win_next = '0;
    for (int c = 0; c < WIN_BLOCKS_X - 1; c++) begin
      for (int r = 0; r < WIN_BLOCKS_Y; r++) begin
        w_win_next[(r*WIN_BLOCKS_X + c)*BLOCK_WIDTH +: BLOCK_WIDTH] = r_win[c+1][r];
      end
    end
    for (int r = 0; r < WIN_BLOCKS_Y; r++) begin
      w_win_next[(r*WIN_BLOCKS_X + WIN_BLOCKS_X - 1)*BLOCK_WIDTH +: BLOCK_WIDTH] = w_col_blk[r];
    end
  end

  // Stage p0 -> p1: position counters and the registered window output
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_px         <= '0;
      r_py         <= '0;
      r_out_valid  <= 1'b0;
      r_out_window <= '0;
      r_out_win_x  <= '0;
      r_out_win_y  <= '0;
      r_out_last   <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_col == COL_LAST) begin
          r_col <= '0;
          r_px  <= '0;
          if (w_row == ROW_LAST) begin
            r_row <= '0;
            r_py  <= '0;
          end else begin
            r_row <= w_row + 1'b1;
            r_py  <= (w_py == PY_LAST) ? '0 : w_py + 1'b1;
          end
        end else begin
          r_col <= w_col + 1'b1;
          r_px  <= (w_px == PX_LAST) ? '0 : w_px + 1'b1;
          r_row <= w_row;
          r_py  <= w_py;
        end
      end
      if (w_accept && w_elig) begin
        r_out_valid  <= 1'b1;
        r_out_window <= w_win_next;
        r_out_win_x  <= w_col - COL_MIN;
        r_out_win_y  <= w_row - ROW_MIN;
        r_out_last   <= (w_col == COL_LAST) && (w_row == ROW_LAST);
      end else if (out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  // Stage p0 storage: line buffer column shift and window column shift, no reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int r = 0; r < LB_ROWS; r++) begin
        r_lb[r][w_col] <= w_col_blk[r+1];
      end
      for (int c = 0; c < WIN_BLOCKS_X - 1; c++) begin
        for (int r = 0; r < WIN_BLOCKS_Y; r++) begin
          r_win[c][r] <= r_win[c+1][r];
        end
      end
      for (int r = 0; r < WIN_BLOCKS_Y; r++) begin
        r_win[WIN_BLOCKS_X-1][r] <= w_col_blk[r];
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_window = r_out_window;
  assign out_win_x  = r_out_win_x;
  assign out_win_y  = r_out_win_y;
  assign out_last   = r_out_last;

endmodule

// File: tb/tb_hog_window_scanner.sv
// Bench for hog_window_scanner on a 6x4 image with 2x2 windows, stride 1 and stride 2,
// compared against a frame-array reference model.
module tb_hog_window_scanner;
  localparam int IX = 6;
  localparam int IY = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_sof, out_ready;
  logic [7:0]  in_block;
  logic        in_ready1, out_valid1, out_last1;
  logic [31:0] out_window1;
  logic [2:0]  out_win_x1;
  logic [1:0]  out_win_y1;
  logic        in_ready2, out_valid2, out_last2;
  logic [31:0] out_window2;
  logic [2:0]  out_win_x2;
  logic [1:0]  out_win_y2;

  hog_window_scanner #(.IMAGE_BLOCKS_X(IX), .IMAGE_BLOCKS_Y(IY), .WIN_BLOCKS_X(2),
    .WIN_BLOCKS_Y(2), .BLOCK_WIDTH(8), .STEP_X(1), .STEP_Y(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_sof(in_sof),
    .in_block(in_block), .out_valid(out_valid1), .out_ready(out_ready),
    .out_window(out_window1), .out_win_x(out_win_x1), .out_win_y(out_win_y1),
    .out_last(out_last1));

  hog_window_scanner #(.IMAGE_BLOCKS_X(IX), .IMAGE_BLOCKS_Y(IY), .WIN_BLOCKS_X(2),
    .WIN_BLOCKS_Y(2), .BLOCK_WIDTH(8), .STEP_X(2), .STEP_Y(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_sof(in_sof),
    .in_block(in_block), .out_valid(out_valid2), .out_ready(out_ready),
    .out_window(out_window2), .out_win_x(out_win_x2), .out_win_y(out_win_y2),
    .out_last(out_last2));

  typedef struct packed {
    logic [31:0] win;
    logic [2:0]  x;
    logic [1:0]  y;
    logic        last;
  } win_t;

  win_t obs1[$], obs2[$], exp1[$], exp2[$];
  int   obs1_cyc[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc_last = 0;
  logic acc;
  int   m_col, m_row;
  logic [7:0] pix [IY][IX];

  // Window whose bottom-right block is image position (c,r), read from the frame array.
  function automatic win_t make_win(int c, int r);
    win_t w;
    w.win  = {pix[r][c], pix[r][c-1], pix[r-1][c], pix[r-1][c-1]};
    w.x    = 3'(c - 1);
    w.y    = 2'(r - 1);
    w.last = (c == IX-1) && (r == IY-1);
    return w;
  endfunction

  task automatic model_accept(input logic sof, input logic [7:0] d);
    if (sof) begin
      m_col = 0;
      m_row = 0;
    end
    pix[m_row][m_col] = d;
    if (m_col >= 1 && m_row >= 1) begin
      exp1.push_back(make_win(m_col, m_row));
      if ((m_col - 1) % 2 == 0 && (m_row - 1) % 2 == 0) exp2.push_back(make_win(m_col, m_row));
    end
    m_col++;
    if (m_col == IX) begin
      m_col = 0;
      m_row = (m_row == IY-1) ? 0 : m_row + 1;
    end
  endtask

  task automatic cycle(input logic v, input logic sof, input logic [7:0] d, input logic rdy);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sof    = sof;
    in_block  = d;
    out_ready = rdy;
    @(negedge clk);
    cyc++;
    acc = v && in_ready1;
    if (out_valid1 && out_ready) begin
      obs1.push_back({out_window1, out_win_x1, out_win_y1, out_last1});
      obs1_cyc.push_back(cyc);
    end
    if (out_valid2 && out_ready) obs2.push_back({out_window2, out_win_x2, out_win_y2, out_last2});
    if (acc) begin
      model_accept(sof, d);
      acc_cyc_last = cyc;
    end
  endtask

  task automatic send(input logic sof, input logic [7:0] d, input int pct_ready);
    int n = 0;
    do begin
      cycle(1'b1, sof, d, ($urandom_range(99) < pct_ready));
      n++;
    end while (!acc && n < 64);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=no_accept want=accept within 64 cycles");
    end
  endtask

  task automatic send_pos(input int pct_ready);
    send(1'b0, 8'(m_row*IX + m_col), pct_ready);
  endtask

  task automatic drain();
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset(input logic rdy);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    out_ready = rdy;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_col = 0;
    m_row = 0;
    obs1.delete(); obs2.delete(); exp1.delete(); exp2.delete(); obs1_cyc.delete();
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    @(negedge clk);
    total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid1); end
    total++; if (out_window1 !== 32'h0) begin bad++; $display("FAIL rst_window got=%h want=0", out_window1); end
    total++; if (out_win_x1 !== 3'd0) begin bad++; $display("FAIL rst_x got=%0d want=0", out_win_x1); end
    total++; if (out_win_y1 !== 2'd0) begin bad++; $display("FAIL rst_y got=%0d want=0", out_win_y1); end
    total++; if (out_last1 !== 1'b0) begin bad++; $display("FAIL rst_last got=%b want=0", out_last1); end
    total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready1); end
    total++; if (out_valid2 !== 1'b0) begin bad++; $display("FAIL rst_valid2 got=%b want=0", out_valid2); end
  endtask

  task automatic test_full_frame();
    int a7 = 0;
    do_reset(1'b1);
    for (int i = 0; i < IX*IY; i++) begin
      send_pos(100);
      if (i == 7) a7 = acc_cyc_last;
    end
    drain();
    total++; if (obs1.size() != 15) begin bad++; $display("FAIL full_count got=%0d want=15", obs1.size()); end
    for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
      total++;
      if (obs1[i] !== exp1[i]) begin bad++; $display("FAIL full_win[%0d] got=%h want=%h", i, obs1[i], exp1[i]); end
    end
    if (obs1.size() == 15) begin
      total++; if (obs1[0] !== {32'h07060100, 3'd0, 2'd0, 1'b0}) begin bad++; $display("FAIL full_first got=%h want=%h", obs1[0], {32'h07060100, 3'd0, 2'd0, 1'b0}); end
      total++; if (obs1_cyc[0] != a7 + 1) begin bad++; $display("FAIL full_latency got=%0d want=%0d", obs1_cyc[0], a7 + 1); end
      total++; if (obs1[14] !== {32'h17161110, 3'd4, 2'd2, 1'b1}) begin bad++; $display("FAIL full_last got=%h want=%h", obs1[14], {32'h17161110, 3'd4, 2'd2, 1'b1}); end
    end
  endtask

  task automatic test_stride();
    int lasts = 0;
    do_reset(1'b1);
    for (int i = 0; i < IX*IY; i++) send_pos(100);
    drain();
    total++; if (obs2.size() != 6) begin bad++; $display("FAIL stride_count got=%0d want=6", obs2.size()); end
    for (int i = 0; i < exp2.size() && i < obs2.size(); i++) begin
      total++;
      if (obs2[i] !== exp2[i]) begin bad++; $display("FAIL stride_win[%0d] got=%h want=%h", i, obs2[i], exp2[i]); end
      if (obs2[i].last) lasts++;
    end
    total++; if (lasts != 1) begin bad++; $display("FAIL stride_last_count got=%0d want=1", lasts); end
  endtask

  task automatic test_backpressure();
    win_t prev = '0;
    win_t cur;
    logic prev_stall = 1'b0;
    int   i = 0;
    int   budget = 0;
    do_reset(1'b1);
    while (i < IX*IY && budget < 600) begin
      cycle(1'b1, 1'b0, 8'(m_row*IX + m_col), 1'($urandom_range(1)));
      budget++;
      cur = {out_window1, out_win_x1, out_win_y1, out_last1};
      total++;
      if (in_ready1 !== (!out_valid1 || out_ready)) begin
        bad++; $display("FAIL bp_in_ready got=%b want=%b", in_ready1, !out_valid1 || out_ready);
      end
      if (prev_stall) begin
        total++;
        if (cur !== prev || out_valid1 !== 1'b1) begin bad++; $display("FAIL bp_stable got=%h want=%h", cur, prev); end
      end
      prev = cur;
      prev_stall = out_valid1 && !out_ready;
      if (acc) i++;
    end
    total++; if (i != IX*IY) begin bad++; $display("FAIL bp_budget got=%0d want=%0d blocks", i, IX*IY); end
    drain();
    total++; if (obs1.size() != 15) begin bad++; $display("FAIL bp_count got=%0d want=15", obs1.size()); end
    for (int k = 0; k < exp1.size() && k < obs1.size(); k++) begin
      total++;
      if (obs1[k] !== exp1[k]) begin bad++; $display("FAIL bp_win[%0d] got=%h want=%h", k, obs1[k], exp1[k]); end
    end
  endtask

  task automatic test_sof();
    int n0;
    int a7 = 0;
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) send(1'b0, 8'(8'h80 | $urandom_range(127)), 100);
    send(1'b1, 8'h00, 100);
    n0 = obs1.size();
    for (int j = 1; j < IX*IY; j++) begin
      send_pos(100);
      if (j == 7) a7 = acc_cyc_last;
    end
    drain();
    total++; if (obs1.size() != 17) begin bad++; $display("FAIL sof_count got=%0d want=17", obs1.size()); end
    for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
      total++;
      if (obs1[i] !== exp1[i]) begin bad++; $display("FAIL sof_win[%0d] got=%h want=%h", i, obs1[i], exp1[i]); end
    end
    if (obs1.size() > n0) begin
      total++; if (obs1[n0] !== {32'h07060100, 3'd0, 2'd0, 1'b0}) begin bad++; $display("FAIL sof_first got=%h want=%h", obs1[n0], {32'h07060100, 3'd0, 2'd0, 1'b0}); end
      total++; if (obs1_cyc[n0] != a7 + 1) begin bad++; $display("FAIL sof_latency got=%0d want=%0d", obs1_cyc[n0], a7 + 1); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) send_pos(100);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    total++; if (out_valid1 !== 1'b1) begin bad++; $display("FAIL rmid_pending got=%b want=1", out_valid1); end
    do_reset(1'b0);
    @(negedge clk);
    total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", out_valid1); end
    total++; if (out_window1 !== 32'h0) begin bad++; $display("FAIL rmid_window got=%h want=0", out_window1); end
    for (int i = 0; i < IX*IY; i++) send_pos(100);
    drain();
    total++; if (obs1.size() != 15) begin bad++; $display("FAIL rmid_count got=%0d want=15", obs1.size()); end
    for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
      total++;
      if (obs1[i] !== exp1[i]) begin bad++; $display("FAIL rmid_win[%0d] got=%h want=%h", i, obs1[i], exp1[i]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    for (int i = 0; i < 2*IX*IY; i++) send_pos(100);
    drain();
    total++; if (obs1.size() != 30) begin bad++; $display("FAIL b2b_count got=%0d want=30", obs1.size()); end
    for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
      total++;
      if (obs1[i] !== exp1[i]) begin bad++; $display("FAIL b2b_win[%0d] got=%h want=%h", i, obs1[i], exp1[i]); end
    end
    if (obs1.size() == 30) begin
      total++; if (obs1[15] !== {32'h07060100, 3'd0, 2'd0, 1'b0}) begin bad++; $display("FAIL b2b_second_first got=%h want=%h", obs1[15], {32'h07060100, 3'd0, 2'd0, 1'b0}); end
      total++; if (obs1[14].last !== 1'b1) begin bad++; $display("FAIL b2b_first_last got=%b want=1", obs1[14].last); end
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_block = 8'h00;
    out_ready = 1'b1;
    test_reset();
    test_full_frame();
    test_stride();
    test_backpressure();
    test_sof();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
